// File: rtl/gan_stream_ctrl.sv
// Streaming sequencer around the fixed-latency generator/discriminator core:
// input handshake, per-sample weight-set select pipe, credit-guarded result FIFO.
module gan_stream_ctrl #(
  parameter int WIDTH      = 32,
  parameter int SEL_W      = 2,
  parameter int N_LAYER    = 4,
  parameter int STAGE_L    = 5,
  parameter int N_PIX      = 9,
  parameter int FIFO_DEPTH = 24,
  parameter int TAG_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic signed [WIDTH-1:0]   in_1,
  input  logic signed [WIDTH-1:0]   in_2,
  output logic signed [WIDTH-1:0]   core_a_1,
  output logic signed [WIDTH-1:0]   core_a_2,
  output logic [N_LAYER*SEL_W-1:0]  layer_sel,
  input  logic [N_PIX*WIDTH-1:0]    core_pix,
  input  logic signed [WIDTH-1:0]   core_disc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PIX*WIDTH-1:0]    out_pix,
  output logic signed [WIDTH-1:0]   out_disc,
  output logic [SEL_W-1:0]          out_sel,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int LAT   = N_LAYER * STAGE_L;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = N_PIX*WIDTH + WIDTH + SEL_W + TAG_W;

  logic [LAT-1:0]   vpipe;
  logic [SEL_W-1:0] spipe [LAT];
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, cred;
  logic [TAG_W-1:0] tag;
  logic             accept, pop, capture;

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign capture = vpipe[LAT-1];

  // Credits cover both in-flight samples and FIFO residents, so the core can
  // never deliver a result the FIFO has no room for.
  assign in_ready  = !rst && (cred < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe    <= '0;
      core_a_1 <= '0;
      core_a_2 <= '0;
      for (int i = 0; i < LAT; i++) spipe[i] <= '0;
    end else begin
      vpipe[0] <= accept;
      spipe[0] <= accept ? in_sel : '0;
      for (int i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        spipe[i] <= spipe[i-1];
      end
      if (accept) begin
        core_a_1 <= in_1;
        core_a_2 <= in_2;
      end
    end
  end

  always_comb begin
    layer_sel = '0;
    for (int l = 0; l < N_LAYER; l++)
      layer_sel[l*SEL_W +: SEL_W] = spipe[l*STAGE_L];
  end

  // Storage carries no reset; stale entries are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {core_pix, core_disc, spipe[LAT-1], tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cred   <= '0;
      tag    <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        tag    <= tag + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   cred <= cred + 1'b1;
        2'b01:   cred <= cred - 1'b1;
        default: cred <= cred;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) assert (count != CNT_W'(FIFO_DEPTH));
  end

  assign head     = mem[rd_ptr];
  assign out_tag  = out_valid ? head[0 +: TAG_W] : '0;
  assign out_sel  = out_valid ? head[TAG_W +: SEL_W] : '0;
  assign out_disc = out_valid ? head[TAG_W+SEL_W +: WIDTH] : '0;
  assign out_pix  = out_valid ? head[TAG_W+SEL_W+WIDTH +: N_PIX*WIDTH] : '0;

endmodule

// File: tb/tb_gan_stream_ctrl.sv
// Scoreboard bench for gan_stream_ctrl: a cycle-indexed core model feeds data,
// expectations are queued at acceptance and compared when results pop.
module tb_gan_stream_ctrl;

  localparam int WIDTH      = 32;
  localparam int SEL_W      = 2;
  localparam int N_LAYER    = 4;
  localparam int STAGE_L    = 5;
  localparam int N_PIX      = 9;
  localparam int FIFO_DEPTH = 24;
  localparam int TAG_W      = 8;
  localparam int LAT        = N_LAYER * STAGE_L;

  typedef struct {
    logic [N_PIX*WIDTH-1:0] pix;
    logic [WIDTH-1:0]       disc;
    logic [SEL_W-1:0]       sel;
    logic [TAG_W-1:0]       tag;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic signed [WIDTH-1:0]   in_1, in_2;
  logic signed [WIDTH-1:0]   core_a_1, core_a_2;
  logic [N_LAYER*SEL_W-1:0]  layer_sel;
  logic [N_PIX*WIDTH-1:0]    core_pix;
  logic signed [WIDTH-1:0]   core_disc;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_PIX*WIDTH-1:0]    out_pix;
  logic signed [WIDTH-1:0]   out_disc;
  logic [SEL_W-1:0]          out_sel;
  logic [TAG_W-1:0]          out_tag;

  exp_t             sb[$];
  logic [TAG_W-1:0] seen_tags[$];
  logic [TAG_W-1:0] tag_model;
  int               edge_n = 0;
  int               n_acc, n_pop;
  int               tests_run = 0;
  int               tests_failed = 0;

  gan_stream_ctrl #(
    .WIDTH(WIDTH), .SEL_W(SEL_W), .N_LAYER(N_LAYER), .STAGE_L(STAGE_L),
    .N_PIX(N_PIX), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_1(in_1), .in_2(in_2),
    .core_a_1(core_a_1), .core_a_2(core_a_2), .layer_sel(layer_sel),
    .core_pix(core_pix), .core_disc(core_disc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_disc(out_disc), .out_sel(out_sel), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [WIDTH-1:0] hword(input int e, input int k);
    logic [31:0] x;
    x = 32'(e) * 32'h9E3779B1 + 32'(k) * 32'h7F4A7C15 + 32'h5BD1E995;
    x = x ^ (x >> 13);
    return x;
  endfunction

  function automatic logic [N_PIX*WIDTH-1:0] pix_of(input int e);
    logic [N_PIX*WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < N_PIX; k++) p[k*WIDTH +: WIDTH] = hword(e, k);
    return p;
  endfunction

  // One clock: core model drives the values sampled at the coming edge,
  // accepts queue expectations, pops are checked against the queue head.
  task automatic tick();
    exp_t e;
    core_pix  = pix_of(edge_n);
    core_disc = hword(edge_n, N_PIX);
    #1;
    if (in_valid && in_ready) begin
      e.pix  = pix_of(edge_n + LAT);
      e.disc = hword(edge_n + LAT, N_PIX);
      e.sel  = in_sel;
      e.tag  = tag_model;
      sb.push_back(e);
      tag_model = tag_model + 1'b1;
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_pop++;
      seen_tags.push_back(out_tag);
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got tag=%0d sel=%0d, required no result", out_tag, out_sel);
      end else begin
        e = sb.pop_front();
        if (out_pix !== e.pix || out_disc !== e.disc || out_sel !== e.sel || out_tag !== e.tag) begin
          tests_failed++;
          $display("[TB] FAIL result: got tag=%0d sel=%0d disc=%h pix=%h, required tag=%0d sel=%0d disc=%h pix=%h",
                   out_tag, out_sel, out_disc, out_pix, e.tag, e.sel, e.disc, e.pix);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); seen_tags.delete();
    tag_model = '0; n_acc = 0; n_pop = 0;
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    tests_run++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending, out_valid=%b, required 0 pending, out_valid=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_sel = '0; in_1 = '0; in_2 = '0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ready_in_reset: got %b, required 0", in_ready);
    end
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || layer_sel !== '0 || core_a_1 !== '0 || core_a_2 !== '0 ||
        out_tag !== '0 || out_sel !== '0 || out_disc !== '0 || out_pix !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b layer_sel=%h a1=%h tag=%0d, required 0 1 0 0 0",
               out_valid, in_ready, layer_sel, core_a_1, out_tag);
    end
  endtask

  task automatic test_single();
    logic [N_LAYER*SEL_W-1:0] exp_ls;
    logic [WIDTH-1:0]         held_disc;
    do_reset();
    in_valid = 1'b1; in_sel = 2'd2; in_1 = 32'h0001_0000; in_2 = 32'hFFFF_0000;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (core_a_1 !== 32'h0001_0000 || core_a_2 !== 32'hFFFF_0000) begin
      tests_failed++;
      $display("[TB] FAIL core_a: got %h %h, required 00010000 ffff0000", core_a_1, core_a_2);
    end
    for (int j = 1; j <= LAT + 1; j++) begin
      exp_ls = '0;
      for (int l = 0; l < N_LAYER; l++)
        if (j == l*STAGE_L + 1) exp_ls[l*SEL_W +: SEL_W] = 2'd2;
      tests_run++;
      if (layer_sel !== exp_ls || out_valid !== (j == LAT + 1)) begin
        tests_failed++;
        $display("[TB] FAIL single_timing cycle %0d: got layer_sel=%h valid=%b, required %h %b",
                 j, layer_sel, out_valid, exp_ls, (j == LAT + 1));
      end
      if (j <= LAT) tick();
    end
    held_disc = out_disc;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_disc !== held_disc || out_sel !== 2'd2 || out_tag !== '0) begin
      tests_failed++;
      $display("[TB] FAIL hold: got valid=%b disc=%h sel=%0d tag=%0d, required 1 %h 2 0",
               out_valid, out_disc, out_sel, out_tag, held_disc);
    end
    drain(10);
  endtask

  task automatic test_back_to_back();
    int drops;
    do_reset();
    drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_sel = SEL_W'(i % 4); in_1 = $urandom; in_2 = $urandom;
      if (!in_ready) drops++;
      tick();
    end
    tests_run++;
    if (drops != 0 || n_acc != 64) begin
      tests_failed++;
      $display("[TB] FAIL full_rate_accept: got drops=%0d accepted=%0d, required 0 64", drops, n_acc);
    end
    drain(100);
    tests_run++;
    if (n_pop != 64) begin
      tests_failed++;
      $display("[TB] FAIL full_rate_results: got %0d, required 64", n_pop);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_sel = SEL_W'(i); in_1 = $urandom; in_2 = $urandom;
      tick();
    end
    tests_run++;
    if (n_acc != FIFO_DEPTH || in_ready !== 1'b0 || dut.count != FIFO_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_fill: got accepted=%0d ready=%b count=%0d, required %0d 0 %0d",
               n_acc, in_ready, dut.count, FIFO_DEPTH, FIFO_DEPTH);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_pop: got %b, required 1", in_ready);
    end
    drain(100);
    tests_run++;
    if (n_pop != FIFO_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_drain: got %0d, required %0d", n_pop, FIFO_DEPTH);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 45; i++) begin
      in_valid = 1'b1; in_sel = SEL_W'(i + 1); in_1 = $urandom; in_2 = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (dut.cred != FIFO_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL cred_full: got %0d, required %0d", dut.cred, FIFO_DEPTH);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (dut.cred != FIFO_DEPTH - 1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cred_after_pop: got cred=%0d ready=%b, required %0d 1", dut.cred, in_ready, FIFO_DEPTH - 1);
    end
    in_valid = 1'b1; in_sel = 2'd3; in_1 = $urandom; in_2 = $urandom;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (dut.cred != FIFO_DEPTH - 1) begin
      tests_failed++;
      $display("[TB] FAIL cred_accept_pop: got %0d, required %0d", dut.cred, FIFO_DEPTH - 1);
    end
    drain(100);
    tests_run++;
    if (n_pop != FIFO_DEPTH + 1) begin
      tests_failed++;
      $display("[TB] FAIL simultaneous_results: got %0d, required %0d", n_pop, FIFO_DEPTH + 1);
    end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1; in_sel = SEL_W'(i); in_1 = $urandom; in_2 = $urandom;
      tick();
    end
    drain(100);
    tests_run++;
    if (seen_tags.size() != 260) begin
      tests_failed++;
      $display("[TB] FAIL tag_wrap_count: got %0d, required 260", seen_tags.size());
    end else if (seen_tags[254] !== 8'd254 || seen_tags[255] !== 8'd255 ||
                 seen_tags[256] !== 8'd0 || seen_tags[257] !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL tag_wrap: got %0d %0d %0d %0d, required 254 255 0 1",
               seen_tags[254], seen_tags[255], seen_tags[256], seen_tags[257]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_1 = $urandom; in_2 = $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (dut.count != 5) begin
      tests_failed++;
      $display("[TB] FAIL mid_setup: got count=%0d, required 5", dut.count);
    end
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || layer_sel !== '0 || dut.cred != 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: got valid=%b layer_sel=%h cred=%0d ready=%b, required 0 0 0 1",
               out_valid, layer_sel, dut.cred, in_ready);
    end
    out_ready = 1'b1;
    repeat (30) tick();
    tests_run++;
    if (n_pop != 0) begin
      tests_failed++;
      $display("[TB] FAIL discarded_emerged: got %0d results, required 0", n_pop);
    end
    in_valid = 1'b1; in_sel = 2'd3; in_1 = $urandom; in_2 = $urandom;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat != LAT) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_latency: got %0d, required %0d", lat, LAT);
    end
    drain(10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
    in_1 = '0; in_2 = '0; core_pix = '0; core_disc = '0;
    tag_model = '0; n_acc = 0; n_pop = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_tag_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gan_stream_ctrl.md
Name: gan_stream_ctrl

Overview:
Streaming sequencer that wraps the fixed-latency generator/discriminator datapath. Generalises the single-bit, 20-stage choice shift register to a SEL_W-bit weight-set select per sample, and to any N_LAYER × STAGE_L latency. Adds a valid/ready input handshake and a credit counter, so the non-stallable core never overruns the output FIFO. Each result leaves with its weight-set select and a sequence tag.

Parameters:
WIDTH, 32, data word width (signed).
SEL_W, 2, weight/bias set select width per sample.
N_LAYER, 4, number of layers in the core pipeline.
STAGE_L, 5, cycles per layer; LAT = N_LAYER*STAGE_L (20).
N_PIX, 9, generator pixel count.
FIFO_DEPTH, 24, output FIFO entries; must be ≥ 1 and a power of 2 is not required.
TAG_W, 8, sequence tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input sample valid
- in_ready  out  1  ready to accept
- in_sel  in  SEL_W  weight-set select for this sample
- in_1, in_2  in  WIDTH  latent inputs (signed)
- core_a_1, core_a_2  out  WIDTH  registered latent to generator
- layer_sel  out  N_LAYER*SEL_W  per-layer memory select
- core_pix  in  N_PIX*WIDTH  generator pixels from core
- core_disc  in  WIDTH  discriminator output from core
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_pix  out  N_PIX*WIDTH  pixels of head result
- out_disc  out  WIDTH  discriminator score of head result
- out_sel  out  SEL_W  select used by head result
- out_tag  out  TAG_W  sequence tag of head result

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all registers clear at the rst edge. Reset values: in_ready=0 while rst=1; core_a_*, layer_sel, out_* = 0; out_valid = 0. Valid pipe, select pipe, FIFO pointers, credit counter and tag all clear.
- Mid-operation reset discards in-flight samples and FIFO contents. out_valid is 0 in the cycle after the reset edge.
- Accept = in_valid & in_ready at a rising edge E. At E:
  - core_a_1/2 ← in_1/2.
  - vpipe[0] ← 1 and spipe[0] ← in_sel.
  - With no accept: vpipe[0] ← 0, spipe[0] ← 0 (bubble). core_a_* hold their value.
- Pipes: vpipe/spipe shift one tap per cycle, LAT taps (index 0..LAT-1).
- Select routing: layer_sel[l*SEL_W +: SEL_W] = spipe[l*STAGE_L] for l = 0..N_LAYER-1.
- Capture: when vpipe[LAT-1] = 1, the edge writes {core_pix, core_disc, spipe[LAT-1], tag} into the FIFO, then tag increments. A sample accepted at edge E is written at edge E+LAT.
- tag wraps 2^TAG_W-1 → 0.
- FIFO: first-word-fall-through from registers. out_* show the head entry; out_valid = (count ≠ 0). Pop = out_valid & out_ready.
- When the FIFO is empty, out_valid rises in the cycle after edge E+LAT (latency LAT cycles from acceptance).
- Output hold: out_* stay stable while out_valid & !out_ready.
- Credit counter cred (0..FIFO_DEPTH) counts samples accepted but not yet popped:
  - +1 on accept, −1 on pop, unchanged on both.
  - in_ready = !rst & (cred < FIFO_DEPTH); no combinational path from out_ready.
  - This guarantees a capture never finds the FIFO full. Overflow is impossible by construction, and a capture into a full FIFO is a checker assertion.
- Throughput: with out_ready held 1, FIFO_DEPTH ≥ LAT+2 sustains one sample per cycle. A smaller depth throttles in_ready without ever losing data.
- Simultaneous capture and pop at the same edge: both happen, and count is unchanged. Capture into an empty FIFO plus out_ready does not bypass the FIFO.
- Ordering: results leave strictly in acceptance order.
- Arithmetic: no arithmetic on data. Data words pass bit-exact, sign untouched.

Test Plan:
- Single sample: in_1=0x00010000, in_2=0xFFFF0000, in_sel=2 accepted at edge 0. Expect: layer_sel field l = 2 exactly during cycles 5l+1..5l+1 (one cycle per tap), zero otherwise. out_valid rises after edge 20 with out_sel=2, out_tag=0, and out_pix/out_disc equal to the core values at edge 20.
- Full-rate stream: 64 back-to-back samples, out_ready=1, sel = i mod 4. Expect: in_ready never drops; 64 results in order; tag 0..63; out_sel = i mod 4.
- Backpressure: out_ready=0, in_valid=1 continuously. Expect: exactly 24 accepted, then in_ready=0. After 24 captures, FIFO count=24 with no overflow. Raising out_ready drains 24 results in order and in_ready reasserts one cycle after the first pop.
- Simultaneous events: with cred=24, hold out_ready=1 for one cycle. Expect: pop, cred=23, in_ready=1 next cycle; accept + pop on the following edge leaves cred at 23.
- Tag wrap: stream 260 samples with TAG_W=8. Expect: out_tag sequence …254, 255, 0, 1…; the 257th result has tag 0.
- Reset mid-operation: assert rst for one cycle with 10 in flight and 5 in the FIFO. Expect: next cycle out_valid=0, layer_sel=0, cred=0. None of the 15 samples emerge, and the next accepted sample gets tag 0 at latency 20.
